// File: rtl/bomb_pkg.sv
// bomb_pkg: shared BCD digit type, limit and clamp helper for the bomb timer.
package bomb_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit with clamped load and 9-wrapping decrement; borrow flags a decrement from 0.
module bcd_down_digit
    import bomb_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  bcd_digit_t loadVal,
    input  logic       dec,
    output bcd_digit_t digit,
    output logic       borrow
);
    assign borrow = dec && (digit == 4'd0);
    always_ff @(posedge clk) begin
        if (!resetN)
            digit <= 4'd0;
        else if (load)
            digit <= bcd_sat(loadVal);
        else if (dec)
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
endmodule

// File: rtl/bomb_timer.sv
// bomb_timer: 2-digit BCD countdown with timerEnd and a free-running duty50 blink.
// Define BOMB_TIMER_WARN_EN to drive warnLamp from a low-time compare against WARN_SEC.
module bomb_timer
    import bomb_pkg::*;
#(
    parameter int BLINK_HALF_CLKS = 25_000_000,
    parameter int WARN_SEC        = 5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       OneSecPulse,
    input  logic       countLoadN,
    input  logic       countEnable,
    input  logic [3:0] presetTens,
    input  logic [3:0] presetOnes,
    output logic [3:0] countTens,
    output logic [3:0] countOnes,
    output logic       timerEnd,
    output logic       duty50,
    output logic       warnLamp
);
    localparam int CW = (BLINK_HALF_CLKS > 1) ? $clog2(BLINK_HALF_CLKS) : 1;

    if (BLINK_HALF_CLKS < 1 || WARN_SEC < 0 || WARN_SEC > 99) begin : gBadParam
        $error("bomb_timer: BLINK_HALF_CLKS must be >=1 and WARN_SEC within 0..99");
    end

    logic          armed, isZero, decReq, onesBorrow, tensBorrow, digitLoad;
    logic [CW-1:0] blinkCnt;
    logic          blinkWrap;

    // A borrow out of the tens digit means a decrement from 00: reload 00 instead of wrapping to 99.
    assign decReq    = countEnable && OneSecPulse;
    assign digitLoad = !countLoadN || tensBorrow;

    bcd_down_digit uOnes (
        .clk    (clk),
        .resetN (resetN),
        .load   (digitLoad),
        .loadVal(countLoadN ? 4'd0 : presetOnes),
        .dec    (decReq),
        .digit  (countOnes),
        .borrow (onesBorrow)
    );

    bcd_down_digit uTens (
        .clk    (clk),
        .resetN (resetN),
        .load   (digitLoad),
        .loadVal(countLoadN ? 4'd0 : presetTens),
        .dec    (onesBorrow),
        .digit  (countTens),
        .borrow (tensBorrow)
    );

    assign isZero    = (countTens == 4'd0) && (countOnes == 4'd0);
    assign timerEnd  = armed && isZero;
    assign blinkWrap = (blinkCnt == CW'(BLINK_HALF_CLKS - 1));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            armed    <= 1'b0;
            blinkCnt <= '0;
            duty50   <= 1'b0;
        end else begin
            if (!countLoadN)
                armed <= 1'b1;
            blinkCnt <= blinkWrap ? '0 : blinkCnt + CW'(1);
            if (blinkWrap)
                duty50 <= ~duty50;
        end
    end

`ifdef BOMB_TIMER_WARN_EN
    localparam logic [7:0] WARN_BCD = {4'(WARN_SEC / 10), 4'(WARN_SEC % 10)};
    assign warnLamp = armed && !isZero && ({countTens, countOnes} <= WARN_BCD);
`else
    assign warnLamp = 1'b0;
`endif
endmodule
